// File: rtl/pid_cmd_pkg.sv
// pid_cmd_pkg: frame header, command codes and FSM state types shared by
// the PID gain command receiver and its byte receiver.
package pid_cmd_pkg;
   localparam logic [7:0] HDR    = 8'hA5;
   localparam logic [7:0] CMD_KP = 8'h01;
   localparam logic [7:0] CMD_KI = 8'h02;
   localparam logic [7:0] CMD_KD = 8'h03;

   typedef enum logic [2:0] {P_IDLE, P_CMD, P_HI, P_LO, P_CHK} pstate_t;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rxstate_t;
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 byte receiver with 2-flop input synchronizer, mid-bit
// sampling and start-bit glitch rejection.
module uart_rx
   import pid_cmd_pkg::*;
#(
   parameter int CLKS_PER_BIT = 1085
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_i,
   input  logic       en_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   output logic       stop_err_o
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

   rxstate_t      state_q;
   logic [1:0]    sync_q;
   logic          prev_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    bit_q;
   logic [7:0]    data_q;
   logic          valid_q;
   logic          stop_err_q;
   logic          rx_s;

   assign rx_s       = sync_q[1];
   assign data_o     = data_q;
   assign valid_o    = valid_q;
   assign stop_err_o = stop_err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         sync_q     <= 2'b11;
         prev_q     <= 1'b1;
         cnt_q      <= '0;
         bit_q      <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         stop_err_q <= 1'b0;
      end else begin
         sync_q     <= {sync_q[0], rx_i};
         prev_q     <= rx_s;
         valid_q    <= 1'b0;
         stop_err_q <= 1'b0;
         if (!en_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  cnt_q <= '0;
                  bit_q <= '0;
                  if (prev_q && !rx_s) state_q <= START;
               end
               START: begin
                  cnt_q <= (cnt_q == HALF) ? '0 : cnt_q + CW'(1);
                  // a start bit that is already high again at mid-bit was a glitch
                  if (cnt_q == HALF) state_q <= rx_s ? IDLE : DATA;
               end
               DATA: begin
                  cnt_q <= (cnt_q == FULL) ? '0 : cnt_q + CW'(1);
                  if (cnt_q == FULL) begin
                     data_q <= {rx_s, data_q[7:1]};
                     bit_q  <= bit_q + 3'd1;
                     if (bit_q == 3'd7) state_q <= STOP;
                  end
               end
               default: begin
                  cnt_q <= (cnt_q == FULL) ? '0 : cnt_q + CW'(1);
                  if (cnt_q == FULL) begin
                     state_q    <= IDLE;
                     valid_q    <= rx_s;
                     stop_err_q <= !rx_s;
                  end
               end
            endcase
         end
      end
   end
endmodule

// File: rtl/uart_pid_cmd_rx.sv
// uart_pid_cmd_rx: parses A5-headed UART command frames into PID gain registers.
// Define UART_PID_CMD_RX_CHECKSUM_EN for 5-byte frames with an XOR checksum byte.
module uart_pid_cmd_rx
   import pid_cmd_pkg::*;
#(
   parameter int CLKS_PER_BIT  = 1085,
   parameter int PID_INT_WIDTH = 16,
   parameter int INITIAL_KP    = 100,
   parameter int INITIAL_KI    = 700,
   parameter int INITIAL_KD    = 700,
   parameter int TIMEOUT_BITS  = 20
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     serial_rx_i,
   input  logic                     rx_en_i,
   output logic [PID_INT_WIDTH-1:0] k_p_o,
   output logic [PID_INT_WIDTH-1:0] k_i_o,
   output logic [PID_INT_WIDTH-1:0] k_d_o,
   output logic                     gain_update_o,
   output logic                     frame_err_o
);
   localparam int TMO = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TW  = $clog2(TMO);

   pstate_t                  state_q;
   logic [1:0]               cmd_q;
   logic [7:0]               hi_q;
   logic [TW-1:0]            tmo_q;
   logic [PID_INT_WIDTH-1:0] k_p_q, k_i_q, k_d_q;
   logic                     upd_q, err_q;
   logic [7:0]               rx_byte;
   logic                     byte_valid, stop_err;
   logic                     cmd_bad, chk_bad, commit, tmo_hit;
   logic [15:0]              word;
   logic [PID_INT_WIDTH-1:0] gain_w;

   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk        (clk),
      .reset      (reset),
      .rx_i       (serial_rx_i),
      .en_i       (rx_en_i),
      .data_o     (rx_byte),
      .valid_o    (byte_valid),
      .stop_err_o (stop_err)
   );

   assign cmd_bad = byte_valid && state_q == P_CMD &&
                    !(rx_byte inside {CMD_KP, CMD_KI, CMD_KD});
   assign tmo_hit = state_q != P_IDLE && tmo_q == TW'(TMO - 1);
   assign gain_w  = PID_INT_WIDTH'(word);

`ifdef UART_PID_CMD_RX_CHECKSUM_EN
   logic [7:0] lo_q;
   // valid command codes fit in two bits, so the cmd byte is {6'b0, cmd_q}
   assign chk_bad = byte_valid && state_q == P_CHK && rx_byte != ({6'b0, cmd_q} ^ hi_q ^ lo_q);
   assign commit  = rx_en_i && byte_valid && state_q == P_CHK && !chk_bad;
   assign word    = {hi_q, lo_q};
   always_ff @(posedge clk or posedge reset) begin
      if (reset) lo_q <= '0;
      else if (byte_valid && state_q == P_LO) lo_q <= rx_byte;
   end
`else
   assign chk_bad = 1'b0;
   assign commit  = rx_en_i && byte_valid && state_q == P_LO;
   assign word    = {hi_q, rx_byte};
`endif

   assign k_p_o         = k_p_q;
   assign k_i_o         = k_i_q;
   assign k_d_o         = k_d_q;
   assign gain_update_o = upd_q;
   assign frame_err_o   = err_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= P_IDLE;
         cmd_q   <= '0;
         hi_q    <= '0;
         tmo_q   <= '0;
         k_p_q   <= PID_INT_WIDTH'(INITIAL_KP);
         k_i_q   <= PID_INT_WIDTH'(INITIAL_KI);
         k_d_q   <= PID_INT_WIDTH'(INITIAL_KD);
         upd_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         upd_q <= commit;
         err_q <= rx_en_i && (stop_err || cmd_bad || chk_bad);
         tmo_q <= (byte_valid || state_q == P_IDLE) ? '0 : tmo_q + TW'(1);
         if (commit) begin
            k_p_q <= (cmd_q == CMD_KP[1:0]) ? gain_w : k_p_q;
            k_i_q <= (cmd_q == CMD_KI[1:0]) ? gain_w : k_i_q;
            k_d_q <= (cmd_q == CMD_KD[1:0]) ? gain_w : k_d_q;
         end
         if (byte_valid && state_q == P_CMD) cmd_q <= rx_byte[1:0];
         if (byte_valid && state_q == P_HI) hi_q <= rx_byte;
         if (!rx_en_i || stop_err) state_q <= P_IDLE;
         else if (byte_valid) begin
            case (state_q)
               P_IDLE:  state_q <= (rx_byte == HDR) ? P_CMD : P_IDLE;
               P_CMD:   state_q <= cmd_bad ? P_IDLE : P_HI;
               P_HI:    state_q <= P_LO;
`ifdef UART_PID_CMD_RX_CHECKSUM_EN
               P_LO:    state_q <= P_CHK;
`endif
               default: state_q <= P_IDLE;
            endcase
         end else if (tmo_hit) state_q <= P_IDLE;
      end
   end
endmodule

// File: tb/tb_uart_pid_cmd_rx.sv
// tb_uart_pid_cmd_rx: directed and randomized UART frames checked against a
// byte-queue frame model; follows UART_PID_CMD_RX_CHECKSUM_EN like the RTL.
module tb_uart_pid_cmd_rx;
   localparam int CLKS = 16;
`ifdef UART_PID_CMD_RX_CHECKSUM_EN
   localparam int FLEN = 5;
`else
   localparam int FLEN = 4;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        serial_rx = 1'b1;
   logic        rx_en = 1'b1;
   logic [15:0] k_p, k_i, k_d;
   logic        gain_update, frame_err;

   int n_tests = 0, n_fail = 0;
   int upd_cnt = 0, err_cnt = 0, both_cnt = 0;
   int exp_upd = 0, exp_err = 0;
   int m_kp = 100, m_ki = 700, m_kd = 700;
   logic [7:0] fq[$];

   uart_pid_cmd_rx #(
      .CLKS_PER_BIT(CLKS), .PID_INT_WIDTH(16), .INITIAL_KP(100),
      .INITIAL_KI(700), .INITIAL_KD(700), .TIMEOUT_BITS(20)
   ) dut (
      .clk(clk), .reset(reset), .serial_rx_i(serial_rx), .rx_en_i(rx_en),
      .k_p_o(k_p), .k_i_o(k_i), .k_d_o(k_d),
      .gain_update_o(gain_update), .frame_err_o(frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (gain_update) upd_cnt++;
      if (frame_err) err_cnt++;
      if (gain_update && frame_err) both_cnt++;
   end

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      repeat (3) @(negedge clk);
      check({tag, "_kp"}, int'(k_p), m_kp);
      check({tag, "_ki"}, int'(k_i), m_ki);
      check({tag, "_kd"}, int'(k_d), m_kd);
      check({tag, "_upd"}, upd_cnt, exp_upd);
      check({tag, "_err"}, err_cnt, exp_err);
   endtask

   // frame-level model: collect bytes after a header and judge the whole frame
   task automatic mdl_byte(input logic [7:0] b);
      logic [15:0] w;
      if (fq.size() == 0 && b != 8'hA5) return;
      fq.push_back(b);
      if (fq.size() == 2 && (b < 8'd1 || b > 8'd3)) begin
         exp_err++;
         fq.delete();
      end else if (fq.size() == FLEN) begin
         w = {fq[2], fq[3]};
         if (FLEN == 5 && fq[4] != (fq[1] ^ fq[2] ^ fq[3])) exp_err++;
         else begin
            exp_upd++;
            if (fq[1] == 8'd1) m_kp = int'(w);
            else if (fq[1] == 8'd2) m_ki = int'(w);
            else m_kd = int'(w);
         end
         fq.delete();
      end
   endtask

   task automatic send_partial(input logic [7:0] b, input int nbits);
      serial_rx = 1'b0;
      repeat (CLKS) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         serial_rx = b[i];
         repeat (CLKS) @(negedge clk);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop_ok);
      send_partial(b, 8);
      serial_rx = stop_ok;
      repeat (CLKS) @(negedge clk);
      serial_rx = 1'b1;
      if (!stop_ok) repeat (CLKS) @(negedge clk);
      if (stop_ok) mdl_byte(b);
      else begin
         exp_err++;
         fq.delete();
      end
   endtask

   task automatic send_seq(input logic [39:0] v, input int n);
      for (int i = 0; i < n; i++) send_byte(v[8*(n-1-i) +: 8], 1'b1);
   endtask

   initial begin
      repeat (5) @(negedge clk);
      check("rst_kp", int'(k_p), 100);
      check("rst_ki", int'(k_i), 700);
      check("rst_kd", int'(k_d), 700);
      check("rst_upd", int'(gain_update), 0);
      check("rst_err", int'(frame_err), 0);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      send_seq(40'hA5_01_01_2C_2C, 5);
      check_all("kp_set");
      send_seq(40'hA5_02_00_64_FF, 5);
      check_all("bad_chk");
      send_byte(8'h55, 1'b0);
      check_all("stop_low");
      send_seq(40'hA5_03_00_0A_09, 5);
      check_all("kd_set");
      send_seq(40'hA5_04_00_01_05, 5);
      check_all("bad_cmd");

      send_seq(40'hA5_01, 2);
      repeat (25 * CLKS) @(negedge clk);
      fq.delete();
      send_seq(40'h00_05_05, 3);
      check_all("timeout");

      send_seq(40'hA5_01_00, 3);
      send_partial(8'h64, 4);
      reset = 1'b1;
      fq.delete();
      m_kp = 100; m_ki = 700; m_kd = 700;
      serial_rx = 1'b1;
      repeat (2) @(negedge clk);
      check("mid_rst_kp", int'(k_p), 100);
      check("mid_rst_ki", int'(k_i), 700);
      reset = 1'b0;
      repeat (CLKS) @(negedge clk);
      send_seq(40'hA5_02_12_34_24, 5);
      check_all("after_rst");

      send_seq(40'hA5_01_00, 3);
      send_partial(8'h64, 4);
      rx_en = 1'b0;
      fq.delete();
      repeat (2) @(negedge clk);
      serial_rx = 1'b1;
      repeat (2 * CLKS) @(negedge clk);
      rx_en = 1'b1;
      repeat (CLKS) @(negedge clk);
      send_byte(8'h65, 1'b1);
      check_all("en_abort");

      send_byte(8'hA5, 1'b1);
      serial_rx = 1'b0;
      repeat (CLKS * 3 / 8) @(negedge clk);
      serial_rx = 1'b1;
      repeat (2 * CLKS) @(negedge clk);
      send_seq(40'h01_00_64_65, 4);
      check_all("glitch");

      for (int f = 0; f < 30; f++) begin
         logic [7:0] cmd, hi, lo, ck;
         cmd = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(1, 3));
         hi = 8'($urandom);
         lo = 8'($urandom);
         ck = cmd ^ hi ^ lo;
         if ($urandom_range(0, 4) == 0) ck = ck ^ 8'($urandom_range(1, 255));
         if ($urandom_range(0, 5) == 0) send_byte(8'($urandom), 1'b1);
         send_seq({8'hA5, cmd, hi, lo, ck}, 5);
         check_all($sformatf("rand%0d", f));
      end

      check("no_overlap", both_cnt, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_pid_cmd_rx.md
UART_PID_CMD_RX -- requirements
Module: uart_pid_cmd_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1085, clk cycles per UART bit (115200 baud at 125 MHz).
REQ-002 Parameter PID_INT_WIDTH, default 16, gain register width.
REQ-003 Parameters INITIAL_KP, INITIAL_KI, INITIAL_KD, defaults 100, 700, 700, gain reset values.
REQ-004 Parameter TIMEOUT_BITS, default 20, allowed inter-byte gap in bit periods before a partial frame is dropped.
REQ-005 clk  input  1  system clock.
REQ-006 reset  input  1  reset, asynchronous, active-high.
REQ-007 serial_rx  input  1  asynchronous UART line; idles high.
REQ-008 rx_en  input  1  enables reception; low holds receiver and parser in idle.
REQ-009 k_p, k_i, k_d  output  PID_INT_WIDTH each  registered, unsigned gain values.
REQ-010 gain_update  output  1  one-cycle pulse when any gain register is written.
REQ-011 frame_err  output  1  one-cycle pulse on a stop-bit, command or checksum error.

Function
REQ-012 serial_rx shall pass through a 2-flop synchronizer before any use.
REQ-013 Byte receiver states: IDLE, START, DATA, STOP.
REQ-014 In IDLE, a synchronized high-to-low transition moves to START.
REQ-015 START samples at CLKS_PER_BIT/2; low moves to DATA, high returns to IDLE with no error (glitch rejection).
REQ-016 DATA samples 8 bits, LSB first, each CLKS_PER_BIT after the previous sample.
REQ-017 STOP samples CLKS_PER_BIT after bit 7; high asserts internal byte_valid for one cycle; low discards the byte, pulses frame_err and returns to IDLE.
REQ-018 Frame format: header 0xA5, cmd, data_hi, data_lo, checksum; checksum = cmd XOR data_hi XOR data_lo.
REQ-019 Command codes: 0x01 k_p, 0x02 k_i, 0x03 k_d.
REQ-020 Parser states: P_IDLE, P_CMD, P_HI, P_LO, P_CHK.
REQ-021 P_IDLE discards every byte except 0xA5, which moves to P_CMD; a discarded byte is not an error.
REQ-022 In P_CMD, a valid code moves to P_HI; any other code pulses frame_err and returns to P_IDLE.
REQ-023 A checksum mismatch in P_CHK pulses frame_err, leaves all gains unchanged and returns to P_IDLE.
REQ-024 A frame is accepted on the cycle after the final byte_valid: the selected gain loads {data_hi,data_lo}, truncated to PID_INT_WIDTH LSBs, and gain_update pulses in that same cycle.
REQ-025 In any state other than P_IDLE, a gap of TIMEOUT_BITS*CLKS_PER_BIT cycles since the last byte_valid returns the parser to P_IDLE silently.
REQ-026 A 0xA5 byte received mid-frame is treated as data, not as a resync.
REQ-027 Deasserting rx_en mid-byte or mid-frame aborts to IDLE/P_IDLE within one cycle; gain registers keep their values; no error pulse.
REQ-028 gain_update and frame_err are never asserted in the same cycle.

Reset
REQ-029 Reset forces k_p=INITIAL_KP, k_i=INITIAL_KI, k_d=INITIAL_KD, gain_update=0, frame_err=0, both FSMs idle, all counters 0 and synchronizer flops 1.
REQ-030 Reset asserted mid-frame discards the partial frame; after release, reception restarts at the next start bit.

Configuration
REQ-031 Macro UART_PID_CMD_RX_CHECKSUM_EN defined: the 5-byte frame and checksum check apply as specified.
REQ-032 Macro undefined: frames are 4 bytes, with no checksum byte; P_CHK is not generated; commit follows data_lo per REQ-024; frame_err covers only stop-bit and command errors.

Structure
REQ-033 Package pid_cmd_pkg holds the header constant 0xA5, the command-code constants, and the parser state enum.
REQ-034 Byte reception shall be a sub-module uart_rx (parameter CLKS_PER_BIT; outputs byte data, byte_valid, stop_err); the frame parser and gain registers reside in uart_pid_cmd_rx.

Verification
REQ-035 Frame A5 01 01 2C 2C at 1085 clk/bit -> k_p=300 and gain_update pulses once, one cycle after the last stop-bit sample; k_i and k_d stay 700.
REQ-036 Frame A5 02 00 64 FF (bad checksum) -> one frame_err pulse, k_i stays 700, no gain_update.
REQ-037 Byte with stop bit driven low -> frame_err pulse; the following valid frame A5 03 00 0A 09 -> k_d=10.
REQ-038 Frame A5 04 00 01 05 -> frame_err pulse at the cmd byte; the remaining bytes are ignored and all gains are unchanged.
REQ-039 Send A5 01, wait 25 bit periods, then send 00 05 05 -> timeout drops the partial frame; no gain change, no frame_err.
REQ-040 Reset or rx_en low asserted during data_lo of A5 01 00 64 65 -> no update; a 400-cycle low glitch on serial_rx produces no byte.
